uart_rx_capture: RTL and testbench
==================================

Name: uart_rx_capture

Overview:
- Clocked UART receiver that consumes the serial TX line of the management SoC UART (mprj_io[6]) and delivers received bytes downstream.
- Recovers 8N1 frames using a programmable bit divider and buffers bytes in a small FIFO behind a valid/ready output.
- Sits between the chip's UART pin and a bench/SoC consumer (character printer, pattern checker); replaces the free-running behavioural receiver with a cycle-accurate one.

Parameters:
- DIV_W, 16, width of the clocks-per-bit divider input
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_div  in  DIV_W  clocks per bit, minus 1; sampled only at start-bit detect; legal values >= 3
- rx_en  in  1  receiver enable; when low, no new frame is accepted
- ser_rx  in  1  serial input, idle high, asynchronous to clock
- rx_data  out  8  FIFO head byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head when rx_valid & rx_ready
- frame_err  out  1  sticky: stop bit sampled low
- overflow  out  1  sticky: byte completed while FIFO full
- err_clr  in  1  clears frame_err and overflow (one-cycle pulse)
- busy  out  1  high from start-bit detect until stop-bit sample

Behaviour:
- Reset (async assert, sync deassert by the consumer's domain): rx_data=0, rx_valid=0, frame_err=0, overflow=0, busy=0; FIFO empty; FSM IDLE; synchronizer flops preset to 1.
- ser_rx passes through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
- FSM states:
  - IDLE: on sync falling edge with rx_en=1, latch clk_div into div_q, load counter with div_q>>1 -> START.
  - START: at counter==0, resample; if low, load div_q -> DATA with bit index 0; if high (glitch), return to IDLE with no error flagged.
  - DATA: at each counter==0, shift the sample into bit [7] (LSB first), reload div_q; after bit 7 -> STOP.
  - STOP: at counter==0:
    - if high, push the byte;
    - if low, set frame_err and discard the byte;
    - then go to IDLE.
    - The line must return high before the next start is detected; a held-low line does not retrigger.
- Counter is a DIV_W down-counter; each bit period is div_q+1 clocks.
- Push-to-rx_valid latency: 1 cycle when the FIFO is empty.
- FIFO: show-ahead, and rx_data holds its value while rx_valid=0.
  - Push when full: byte dropped, overflow set, contents unchanged.
  - Simultaneous push and pop when full: both succeed, no overflow.
- err_clr is ignored in the same cycle a new error is set (set wins).
- rx_en falling mid-frame does not abort the current frame.
- Reset mid-frame: frame abandoned, FIFO flushed.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, sampling one even-parity bit.
  - New output parity_err (1, sticky, cleared by err_clr) is set on mismatch and the byte is discarded.
  - Frame length becomes 11 bits.
- When undefined: port absent, frame is 10 bits (8N1).

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - constant DATA_BITS=8
  - constant SYNC_STAGES=2
- One sub-module, uart_rx_fifo: parameterized show-ahead FIFO with push/pop/full/empty, instantiated once.
- The FSM, synchronizer and counter stay in the top.

Test Plan:
- clk_div=15, send 0x55 then 0xA3 with correct stop bits, rx_ready=1 -> rx_data 0x55 then 0xA3, one rx_valid pulse each, frame_err=0.
- clk_div=15, 4-clock low glitch on ser_rx -> FSM returns to IDLE, rx_valid stays 0, frame_err stays 0.
- clk_div=15, send 0x41 with stop bit low -> frame_err=1, no byte pushed; err_clr pulse -> frame_err=0.
- rx_ready=0, send 5 bytes 0x10..0x14 with FIFO_DEPTH=4 -> overflow=1; draining yields 0x10..0x13 only.
- clk_div=346 (40 MHz, 115200 baud), send "AB" back-to-back -> bytes 0x41, 0x42; busy high for each frame, low between them.
- UART_RX_PARITY_EN, send 0x07 with parity bit 0 (odd count, wrong) -> parity_err=1, no byte; send 0x07 with parity 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_capture_pkg.sv
// uart_rx_pkg: shared constants and FSM state type for the UART capture block.
//   DATA_BITS   - payload bits per frame (LSB first)
//   SYNC_STAGES - depth of the ser_rx metastability synchronizer
//   rx_state_e  - receiver FSM states (PARITY only reached with UART_RX_PARITY_EN)
package uart_rx_pkg;
  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;
endpackage

// File: rtl/uart_rx_capture_if.sv
// uart_rx_capture_if: received-byte stream (valid/ready).
//   rx_data  - head byte
//   rx_valid - head byte present
//   rx_ready - consumer accepts head when rx_valid & rx_ready
// master = receiver side, slave = consumer side.
interface uart_rx_capture_if;
  import uart_rx_pkg::*;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_capture_fifo.sv
// uart_rx_fifo: show-ahead FIFO for received bytes.
//   clock/reset - system clock, async active-high reset
//   push/push_data - write request; ignored when full unless a pop happens the same cycle
//   pop         - consume head (ignored when empty)
//   head        - current head; holds the last popped value while empty
//   full/empty  - occupancy flags
//   dropped     - push rejected because the FIFO was full
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             dropped
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign head    = empty ? last_q : mem[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr   <= rptr + 1'b1;
        last_q <= mem[rptr[AW-1:0]];
      end
    end
  end

  // storage needs no reset: entries are only visible once written
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: cycle-accurate 8N1 UART receiver with byte FIFO.
//   clock, reset - system clock, async active-high reset
//   clk_div      - clocks per bit minus 1, latched at start-bit detect (>= 3)
//   rx_en        - allow new frames to start
//   ser_rx       - async serial input, idle high
//   rx_if        - byte stream out (master modport)
//   frame_err    - sticky, stop bit sampled low
//   overflow     - sticky, byte completed while FIFO full
//   err_clr      - one-cycle clear of sticky errors (a same-cycle set wins)
//   busy         - frame in progress
//   parity_err   - sticky even-parity mismatch (only with UART_RX_PARITY_EN)
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a parity check.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              rx_en,
  input  logic              ser_rx,
  uart_rx_capture_if.master rx_if,
  output logic              frame_err,
  output logic              overflow,
  input  logic              err_clr,
  output logic              busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int IW = $clog2(DATA_BITS);

  // synchronizer and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev, rx_fall;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev & ~rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ser_rx};
      rx_prev <= rx_s;
    end
  end

  // FSM + datapath registers
  rx_state_e            state, state_d;
  logic [DIV_W-1:0]     cnt, cnt_d, div_q, div_d;
  logic [IW-1:0]        idx, idx_d;
  logic [DATA_BITS-1:0] sh, sh_d;
  logic                 pbad, pbad_d;
  logic                 push, ferr_set, perr_set, tick0;

  assign tick0 = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      div_q <= '0;
      idx   <= '0;
      sh    <= '0;
      pbad  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      div_q <= div_d;
      idx   <= idx_d;
      sh    <= sh_d;
      pbad  <= pbad_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    div_d    = div_q;
    idx_d    = idx;
    sh_d     = sh;
    pbad_d   = pbad;
    push     = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    unique case (state)
      IDLE: begin
        // edge-triggered start: a line held low cannot retrigger
        if (rx_fall && rx_en) begin
          div_d   = clk_div;
          cnt_d   = clk_div >> 1;   // land on mid start bit
          pbad_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (!tick0)     cnt_d = cnt - 1'b1;
        else if (!rx_s) begin
          cnt_d   = div_q;
          idx_d   = '0;
          state_d = DATA;
        end else        state_d = IDLE;   // glitch, silently dropped
      end
      DATA: begin
        if (!tick0) cnt_d = cnt - 1'b1;
        else begin
          sh_d  = {rx_s, sh[DATA_BITS-1:1]};
          cnt_d = div_q;
          idx_d = idx + 1'b1;
          if (idx == IW'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (!tick0) cnt_d = cnt - 1'b1;
        else begin
          cnt_d   = div_q;
          state_d = STOP;
          if (rx_s != ^sh) begin
            perr_set = 1'b1;
            pbad_d   = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (!tick0) cnt_d = cnt - 1'b1;
        else begin
          state_d = IDLE;
          if (!rx_s)      ferr_set = 1'b1;
          else if (!pbad) push     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // output FIFO
  logic fifo_full, fifo_empty, fifo_drop;

  uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (sh),
    .pop       (rx_if.rx_ready),
    .head      (rx_if.rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_drop)
  );

  assign rx_if.rx_valid = ~fifo_empty;

  // sticky errors
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (fifo_drop)    overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         parity_err <= 1'b0;
    else if (perr_set) parity_err <= 1'b1;
    else if (err_clr)  parity_err <= 1'b0;
  end
`endif

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture; parity steps run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_capture;
  logic        clock = 1'b0;
  logic        reset, rx_en, ser_rx, err_clr;
  logic        frame_err, overflow, busy;
  logic [15:0] clk_div;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] got[$];
  int   busy_rises = 0;
  logic busy_prev  = 1'b0;

  uart_rx_capture_if rx_if ();

  uart_rx_capture #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .clk_div   (clk_div),
    .rx_en     (rx_en),
    .ser_rx    (ser_rx),
    .rx_if     (rx_if),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_clr   (err_clr),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clock = ~clock;

  // capture accepted bytes and busy rising edges away from the active edge
  always @(negedge clock) begin
    if (rx_if.rx_valid && rx_if.rx_ready) got.push_back(rx_if.rx_data);
    if (busy && !busy_prev) busy_rises++;
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_rx = b;
    tick(int'(clk_div) + 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
    ser_rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    reset = 1'b1; rx_en = 1'b1; ser_rx = 1'b1; err_clr = 1'b0;
    clk_div = 16'd15; rx_if.rx_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", rx_if.rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    // two good frames
    got.delete();
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    tick(5);
    check("t1_count", got.size(), 2);
    check("t1_byte0", got[0], 8'h55);
    check("t1_byte1", got[1], 8'hA3);
    check("t1_ferr", frame_err, 0);

    // 4-clock glitch: start rejected at mid-bit resample
    got.delete();
    ser_rx = 1'b0;
    tick(4);
    ser_rx = 1'b1;
    tick(3);
    check("gl_busy_mid", busy, 1);
    tick(30);
    check("gl_busy_end", busy, 0);
    check("gl_valid", rx_if.rx_valid, 0);
    check("gl_ferr", frame_err, 0);
    check("gl_count", got.size(), 0);

    // stop bit low
    send_frame(8'h41, 1'b0);
    tick(4);
    check("fe_set", frame_err, 1);
    check("fe_count", got.size(), 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("fe_clr", frame_err, 0);

    // overflow: five bytes into a 4-deep FIFO
    rx_if.rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    tick(4);
    check("ov_set", overflow, 1);
    check("ov_valid", rx_if.rx_valid, 1);
    check("ov_head", rx_if.rx_data, 8'h10);
    rx_if.rx_ready = 1'b1;
    tick(8);
    check("ov_count", got.size(), 4);
    check("ov_b0", got[0], 8'h10);
    check("ov_b1", got[1], 8'h11);
    check("ov_b2", got[2], 8'h12);
    check("ov_b3", got[3], 8'h13);
    check("ov_empty", rx_if.rx_valid, 0);
    check("ov_hold", rx_if.rx_data, 8'h13);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ov_clr", overflow, 0);

    // reset mid-frame flushes FIFO and abandons frame
    rx_if.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    tick(4);
    check("rm_valid_pre", rx_if.rx_valid, 1);
    ser_rx = 1'b0;
    tick(40);
    check("rm_busy_pre", busy, 1);
    reset = 1'b1;
    tick(1);
    check("rm_busy", busy, 0);
    check("rm_valid", rx_if.rx_valid, 0);
    check("rm_data", rx_if.rx_data, 0);
    ser_rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);
    check("rm_idle", busy, 0);
    check("rm_valid_post", rx_if.rx_valid, 0);
    rx_if.rx_ready = 1'b1;

    // 115200 baud at 40 MHz, back-to-back "AB"
    clk_div = 16'd346;
    got.delete();
    busy_rises = 0;
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    tick(5);
    check("ab_count", got.size(), 2);
    check("ab_b0", got[0], 8'h41);
    check("ab_b1", got[1], 8'h42);
    check("ab_busy_frames", busy_rises, 2);
    check("ab_busy_end", busy, 0);
    clk_div = 16'd15;

`ifdef UART_RX_PARITY_EN
    got.delete();
    send_frame_p(8'h07, 1'b0);
    tick(4);
    check("par_err", parity_err, 1);
    check("par_drop", got.size(), 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("par_clr", parity_err, 0);
    send_frame_p(8'h07, 1'b1);
    tick(4);
    check("par_ok_count", got.size(), 1);
    check("par_ok_byte", got[0], 8'h07);
    check("par_ok_err", parity_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
